// File: rtl/uart_rx_if.sv
// Receive-side bus of the UART: serial line in, byte handshake and error pulses out.
// The receiver connects through the slave modport; the consumer/driver uses master.
interface uart_rx_if;
    logic       rx;
    logic       ack;
    logic [7:0] dout;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    modport master (
        output rx,
        output ack,
        input  dout,
        input  valid,
        input  frame_err,
        input  overrun
    );

    modport slave (
        input  rx,
        input  ack,
        output dout,
        output valid,
        output frame_err,
        output overrun
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority per bit, valid/ack byte handshake.
// Define UART_RX_PARITY_EN for 8E1 framing (even parity bit checked before the stop bit).
module uart_rx #(
    parameter int CLKS_PER_TICK = 326
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    uart_rx_if.slave bus
);

    localparam int TW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_e;

    state_e        state_q, state_d;
    logic          s1_q, s2_q, s3_q;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]    smp_cnt_q, smp_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          smp7_q, smp7_d;
    logic          smp8_q, smp8_d;
    logic [7:0]    dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
    logic          par_q, par_d;
`endif

    logic fall, tick, maj, decide, boundary, frame_ok, deliver;

    // Falling edge only after the line has been seen high, so a held-low break re-arms on release
    assign fall     = s3_q & ~s2_q;
    assign tick     = (tick_cnt_q == TW'(CLKS_PER_TICK - 1));
    assign maj      = (smp7_q & smp8_q) | (smp7_q & s2_q) | (smp8_q & s2_q);
    assign decide   = tick && (smp_cnt_q == 4'd8);
    assign boundary = tick && (smp_cnt_q == 4'd15);
`ifdef UART_RX_PARITY_EN
    assign frame_ok = maj & ~(^{shift_q, par_q});
`else
    assign frame_ok = maj;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
            s3_q       <= 1'b1;
            tick_cnt_q <= '0;
            smp_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            smp7_q     <= 1'b1;
            smp8_q     <= 1'b1;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            s1_q       <= bus.rx;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            tick_cnt_q <= tick_cnt_d;
            smp_cnt_q  <= smp_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            smp7_q     <= smp7_d;
            smp8_q     <= smp8_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        smp_cnt_d  = tick ? smp_cnt_q + 4'd1 : smp_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        smp7_d     = (tick && smp_cnt_q == 4'd6) ? s2_q : smp7_q;
        smp8_d     = (tick && smp_cnt_q == 4'd7) ? s2_q : smp8_q;
        dout_d     = dout_q;
        valid_d    = valid_q;
        ferr_d     = 1'b0;
        ovr_d      = 1'b0;
        deliver    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d      = par_q;
`endif

        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                    smp_cnt_d  = '0;
                    bit_cnt_d  = '0;
                end
            end
            START: begin
                if (decide && maj) begin
                    state_d = IDLE;
                end else if (boundary) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (decide) begin
                    shift_d = {maj, shift_q[7:1]};
                end
                if (boundary) begin
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (decide) begin
                    par_d = maj;
                end
                if (boundary) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // Leave at mid-stop so the next start edge is caught as early as possible
                if (decide) begin
                    state_d = IDLE;
                    if (frame_ok) begin
                        deliver = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (deliver) begin
            if (!valid_q || bus.ack) begin
                dout_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (bus.ack && valid_q) begin
            valid_d = 1'b0;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_TICK=4: delivery timing, overrun, framing, glitches, reset.
// Builds for 8N1 by default and for 8E1 when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

    localparam int CPT      = 4;
    localparam int BIT_CLKS = 16 * CPT;
`ifdef UART_RX_PARITY_EN
    localparam int DEC_TICK = 169;
`else
    localparam int DEC_TICK = 153;
`endif
    localparam int LAT = 2 + DEC_TICK * CPT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    uart_rx_if bus();

    uart_rx #(.CLKS_PER_TICK(CPT)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_k = 0;
    int rise_cyc = -1;
    int fe_cyc = -1;
    int ov_cyc = -1;
    int fe_cnt = 0;
    int ov_cnt = 0;
    logic valid_prev = 1'b0;

    // Event capture: counts pulse cycles and remembers when valid last rose
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (bus.frame_err === 1'b1) begin fe_cnt++; fe_cyc = cyc; end
        if (bus.overrun === 1'b1) begin ov_cnt++; ov_cyc = cyc; end
        if (bus.valid === 1'b1 && valid_prev !== 1'b1) rise_cyc = cyc;
        valid_prev = bus.valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_bad,
                              input logic glitch);
        logic [10:0] bits;
        int nb;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
`ifdef UART_RX_PARITY_EN
        bits[9]  = (^d) ^ par_bad;
        bits[10] = stop_b;
        nb = 11;
`else
        bits[9]  = stop_b;
        bits[10] = (^d) ^ par_bad;
        nb = 10;
`endif
        @(negedge clk);
        last_k = cyc + 1;
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < BIT_CLKS; j++) begin
                bus.rx = bits[b];
                if (glitch && b == 4 && j >= 8*CPT-2 && j <= 8*CPT+1) bus.rx = ~bits[b];
                @(negedge clk);
            end
        end
        bus.rx = 1'b1;
    endtask

    task automatic test_reset();
        bus.rx  = 1'b1;
        bus.ack = 1'b0;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", bus.dout); end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++; if ({bus.frame_err, bus.overrun, bus.valid} !== 3'b000)
            begin errors++; $display("FAIL idle_flags: got %b want 000", {bus.frame_err, bus.overrun, bus.valid}); end
    endtask

    task automatic test_basic();
        int fe0 = fe_cnt, ov0 = ov_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        checks++; if (bus.dout !== 8'hA5) begin errors++; $display("FAIL basic_dout: got %h want a5", bus.dout); end
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", bus.valid); end
        checks++; if (rise_cyc !== last_k + LAT) begin errors++; $display("FAIL basic_latency: got %0d want %0d", rise_cyc, last_k + LAT); end
        checks++; if (fe_cnt - fe0 !== 0 || ov_cnt - ov0 !== 0)
            begin errors++; $display("FAIL basic_flags: got fe=%0d ov=%0d want 0 0", fe_cnt - fe0, ov_cnt - ov0); end
        @(negedge clk); bus.ack = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL basic_ack: got %b want 0", bus.valid); end
        @(negedge clk); bus.ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        int ov0 = ov_cnt, fe0 = fe_cnt;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        checks++; if (bus.dout !== 8'h3C) begin errors++; $display("FAIL ovr_dout: got %h want 3c", bus.dout); end
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b want 1", bus.valid); end
        checks++; if (ov_cnt - ov0 !== 1) begin errors++; $display("FAIL ovr_count: got %0d want 1", ov_cnt - ov0); end
        checks++; if (ov_cyc !== last_k + LAT) begin errors++; $display("FAIL ovr_time: got %0d want %0d", ov_cyc, last_k + LAT); end
        checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL ovr_fe: got %0d want 0", fe_cnt - fe0); end
        @(negedge clk); bus.ack = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL ovr_ack: got %b want 0", bus.valid); end
        @(negedge clk); bus.ack = 1'b0;
    endtask

    task automatic test_frame_err();
        int fe0 = fe_cnt;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", fe_cnt - fe0); end
        checks++; if (fe_cyc !== last_k + LAT) begin errors++; $display("FAIL ferr_time: got %0d want %0d", fe_cyc, last_k + LAT); end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL ferr_valid: got %b want 0", bus.valid); end
        fe0 = fe_cnt;
        @(negedge clk); bus.rx = 1'b0;
        repeat (3 * 10 * BIT_CLKS) @(negedge clk);
        bus.rx = 1'b1;
        repeat (100) @(negedge clk);
        checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL break_count: got %0d want 1", fe_cnt - fe0); end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL break_valid: got %b want 0", bus.valid); end
    endtask

    task automatic test_start_glitch();
        int fe0 = fe_cnt, ov0 = ov_cnt;
        @(negedge clk); bus.rx = 1'b0;
        repeat (5 * CPT) @(negedge clk);
        bus.rx = 1'b1;
        repeat (100) @(negedge clk);
        checks++; if ({bus.valid, fe_cnt - fe0, ov_cnt - ov0} !== {1'b0, 32'd0, 32'd0})
            begin errors++; $display("FAIL glitch_quiet: got valid=%b fe=%0d ov=%0d want 0 0 0", bus.valid, fe_cnt - fe0, ov_cnt - ov0); end
        send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        checks++; if (bus.dout !== 8'h0F || bus.valid !== 1'b1)
            begin errors++; $display("FAIL after_glitch: got %h/%b want 0f/1", bus.dout, bus.valid); end
        @(negedge clk); bus.ack = 1'b1;
        @(negedge clk); bus.ack = 1'b0;
    endtask

    task automatic test_majority_and_reset();
        int fe0, ov0;
        send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        checks++; if (bus.dout !== 8'hFF || bus.valid !== 1'b1)
            begin errors++; $display("FAIL majority: got %h/%b want ff/1", bus.dout, bus.valid); end
        @(negedge clk); bus.rx = 1'b0;
        repeat (5 * BIT_CLKS / 2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({bus.dout, bus.valid, bus.frame_err, bus.overrun} !== 11'd0)
            begin errors++; $display("FAIL async_reset: got %h/%b%b%b want 00/000", bus.dout, bus.valid, bus.frame_err, bus.overrun); end
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        checks++; if (bus.dout !== 8'h81 || bus.valid !== 1'b1)
            begin errors++; $display("FAIL post_reset: got %h/%b want 81/1", bus.dout, bus.valid); end
        checks++; if (fe_cnt - fe0 !== 0 || ov_cnt - ov0 !== 0)
            begin errors++; $display("FAIL post_reset_flags: got fe=%0d ov=%0d want 0 0", fe_cnt - fe0, ov_cnt - ov0); end
        @(negedge clk); bus.ack = 1'b1;
        @(negedge clk); bus.ack = 1'b0;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int fe0 = fe_cnt;
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        checks++; if (bus.dout !== 8'h07 || bus.valid !== 1'b1)
            begin errors++; $display("FAIL parity_good: got %h/%b want 07/1", bus.dout, bus.valid); end
        checks++; if (rise_cyc !== last_k + LAT) begin errors++; $display("FAIL parity_latency: got %0d want %0d", rise_cyc, last_k + LAT); end
        @(negedge clk); bus.ack = 1'b1;
        @(negedge clk); bus.ack = 1'b0;
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL parity_bad_fe: got %0d want 1", fe_cnt - fe0); end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL parity_bad_valid: got %b want 0", bus.valid); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_frame_err();
        test_start_glitch();
        test_majority_and_reset();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART datapath: the counterpart of the transmit stage, consuming an asynchronous 8N1 line and presenting bytes to the fabric. It synchronises the line, detects the start edge, samples each bit with 16x oversampling and 3-sample majority vote, and checks the stop bit. Received bytes are held on a valid/ack handshake, with frame-error and overrun flags. A single system clock drives everything; the 16x sample tick is generated internally.

## Interface
- CLKS_PER_TICK, 326: system clocks per 16x-oversample tick (50 MHz / (9600·16)); legal range ≥ 2.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rx  in  1  serial line, idle high, asynchronous to clk.
- ack  in  1  consumer accepts dout; clears valid.
- dout  out  8  received byte, LSB received first; reset 8'h00.
- valid  out  1  dout holds an unconsumed byte; reset 0.
- frame_err  out  1  one-cycle pulse: stop bit sampled low (or parity failed); reset 0.
- overrun  out  1  one-cycle pulse: good byte arrived while valid=1 and no ack; reset 0.

## Operation
- Synchroniser: s1<=rx, s2<=s1, s3<=s2, all reset to 1. fall = s3 & ~s2.
- Tick counter: 0..CLKS_PER_TICK-1, tick is one-cycle strobe at terminal count; counter forced to 0 on start detection.
- Sample counter s (4 bit): cleared on start detection and at each bit boundary; increments per tick; bit boundary after 16 ticks.
- Bit value: majority of s2 sampled on ticks 7, 8, 9 of the bit; decision made on tick 9.
- States: IDLE, START, DATA, (PARITY), STOP.
- IDLE: on fall -> START.
- START: at tick-9 decision, majority 1 -> IDLE (glitch rejected, no flags); 0 -> wait to bit boundary -> DATA.
- DATA: 8 bits, shifted in LSB first; bit counter 0..7; after bit 7 boundary -> PARITY or STOP.
- STOP: at tick-9 decision go IDLE immediately (half-bit early, for resync). Stop=1 and no error: deliver byte. Stop=0: frame_err pulse, byte discarded.
- Delivery: valid=0 or ack=1 that cycle -> dout<=byte, valid<=1. valid=1 and ack=0 -> overrun pulse, new byte dropped, dout unchanged.
- ack with valid=1 and no delivery -> valid<=0. ack with valid=0 ignored.
- A break (line held low) yields one frame_err; no new start until line returns high (fall requires s3=1).
- Reset mid-frame: all state, counters, outputs to reset values asynchronously; reception resumes on next falling edge after release.

## Timing
- Let edge k be the first clk edge sampling rx low into s1. START is entered at edge k+2.
- Tick n after detection occurs at edge k+2+n·CLKS_PER_TICK.
- Stop decision on tick 153 (9·16+9): valid/frame_err/overrun update at edge k+2+153·CLKS_PER_TICK; with parity, tick 169.
- valid stays high until the edge after ack is sampled high; frame_err/overrun are exactly one cycle wide.
- Back-to-back frames: next start edge may arrive any time after the stop decision; ≥ 6 ticks margin before next bit centre.

## Configuration
- UART_RX_PARITY_EN defined: frame is 8E1; PARITY state samples a ninth bit after DATA; byte delivered only if XOR of data and parity bit = 0 and stop=1, otherwise frame_err pulse and byte discarded. Stop decision at tick 169.
- Undefined: 8N1, PARITY state and logic absent, stop decision at tick 153.

## Test plan
- CLKS_PER_TICK=4, 8N1, send 8'hA5, ack held low -> dout=8'hA5, valid high at k+2+612, no flags.
- Send 8'h3C then 8'hC3 without ack -> dout stays 8'h3C, one-cycle overrun on second frame; ack then -> valid low next edge.
- Stop bit driven low on 8'h55 -> frame_err pulse at stop decision, valid stays 0; hold line low 3 frames -> exactly one frame_err.
- rx low pulse of 5 ticks from idle -> no valid, no flags, returns to IDLE; following real 8'h0F received correctly.
- Single-tick glitch on tick 8 of data bit 3 of 8'hFF -> majority yields 8'hFF; assert rst low mid-byte -> all outputs 0 immediately, next frame 8'h81 received cleanly.
- UART_RX_PARITY_EN: 8'h07 with parity 1 -> delivered; parity 0 -> frame_err, valid 0.
